// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder: diagonal-skew feeder for the left PE column.
// Tags the first vector of each matrix with a per-row weight switch.
module systolic_input_feeder #(
  parameter int ROWS       = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       feed_start_in,
  input  logic                       vec_valid_in,
  input  logic                       vec_last_in,
  input  logic [ROWS*DATA_WIDTH-1:0] vec_data_in,
  output logic                       vec_ready_out,
  output logic [ROWS-1:0]            sys_valid_out,
  output logic [ROWS*DATA_WIDTH-1:0] sys_data_out,
  output logic [ROWS-1:0]            sys_switch_out,
  output logic                       feed_busy_out,
  output logic                       feed_done_out
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ROWS - 1);

  state_t        state;
  logic          ready_q;
  logic          switch_pending;
  logic [CW-1:0] drain_cnt;
  logic          accept;
  logic          beat_sw;

  assign accept  = vec_valid_in & ready_q;
  assign beat_sw = accept & switch_pending;

  // Stream control: start, accept, last-beat drain countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ready_q        <= 1'b0;
      switch_pending <= 1'b0;
      drain_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (feed_start_in) begin
            state          <= STREAM;
            ready_q        <= 1'b1;
            switch_pending <= 1'b1;
          end
        end
        STREAM: begin
          if (accept) begin
            switch_pending <= 1'b0;
            if (vec_last_in) begin
              state     <= DRAIN;
              ready_q   <= 1'b0;
              drain_cnt <= CNT_INIT;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign vec_ready_out = ready_q;
  assign feed_busy_out = (state != IDLE);
  assign feed_done_out = (state == DRAIN) && (drain_cnt == '0);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0]            v_sr;
    logic [r:0]            s_sr;
    logic [DATA_WIDTH-1:0] d_sr [r+1];
    logic [DATA_WIDTH-1:0] d_in;

    assign d_in = accept ? vec_data_in[r*DATA_WIDTH +: DATA_WIDTH] : '0;

    // Row r delay line of r+1 stages; bubbles shift like beats.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_sr <= '0;
        s_sr <= '0;
        for (int i = 0; i <= r; i++) d_sr[i] <= '0;
      end else begin
        v_sr[0] <= accept;
        s_sr[0] <= beat_sw;
        d_sr[0] <= d_in;
        for (int i = 1; i <= r; i++) begin
          v_sr[i] <= v_sr[i-1];
          s_sr[i] <= s_sr[i-1];
          d_sr[i] <= d_sr[i-1];
        end
      end
    end

    assign sys_valid_out[r]                         = v_sr[r];
    assign sys_switch_out[r]                        = s_sr[r];
    assign sys_data_out[r*DATA_WIDTH +: DATA_WIDTH] = d_sr[r];
  end

endmodule

// File: doc/systolic_input_feeder.md
Name: systolic_input_feeder

Overview:
Upstream stage of the systolic array. It accepts one Q8.8 activation vector per cycle (one element per PE row) and applies diagonal skew, delaying row r by r extra cycles. It then drives the pe_valid_in, pe_input_in and pe_switch_in ports of the left-column PEs. It tags the first vector of each new matrix with a switch pulse so each row's PE swaps its inactive weight into the active register exactly when its first input arrives.

Parameters:
ROWS, 2, number of PE rows fed (≥1)
DATA_WIDTH, 16, element width (Q8.8 signed fixed point)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
feed_start_in  input  1  single-cycle pulse that starts a matrix stream; honoured only in IDLE
vec_valid_in  input  1  upstream vector valid
vec_last_in  input  1  marks the final vector of the matrix; qualified by valid&ready
vec_data_in  input  ROWS*DATA_WIDTH  element r at bits [r*DATA_WIDTH +: DATA_WIDTH]
vec_ready_out  output  1  feeder accepts a vector this cycle
sys_valid_out  output  ROWS  per-row valid to the left-column PE
sys_data_out  output  ROWS*DATA_WIDTH  per-row input to the left-column PE
sys_switch_out  output  ROWS  per-row weight-switch pulse
feed_busy_out  output  1  state != IDLE
feed_done_out  output  1  one-cycle pulse when the last element leaves the last row

Behaviour:
- Reset: rst=0 asynchronously clears all registers. State=IDLE. All outputs are 0, including vec_ready_out, busy and done. Assertion mid-stream aborts the stream; there is no partial drain.
- States: IDLE, STREAM, DRAIN. vec_ready_out=1 only in STREAM (registered, Moore).
- IDLE: feed_start_in=1 -> STREAM and sets switch_pending=1. All other inputs are ignored.
- STREAM: accept = vec_valid_in & vec_ready_out.
  - On accept, the beat carries switch = switch_pending, then switch_pending clears.
  - On accept with vec_last_in=1 -> DRAIN, and drain_cnt loads ROWS-1.
  - vec_last_in without valid is ignored.
- DRAIN: drain_cnt decrements each cycle. feed_done_out = (state==DRAIN && drain_cnt==0). At the next edge the state returns to IDLE. feed_start_in is ignored in STREAM and DRAIN.
- Skew pipeline: row r holds r+1 registers; all registers shift every cycle, including bubbles and DRAIN.
- Latency: an element accepted at edge E appears on row r after edge E+r. Row 0 is visible the cycle after acceptance.
- Non-accepted cycles inject a bubble: valid=0, data=0, switch=0. Outputs are therefore 0 whenever the matching valid is 0.
- Data is passed bit-exact with no arithmetic. Switch and valid travel in the same skew registers as their element.
- Timing check: the last beat accepted at E0 exits row ROWS-1 after E0+ROWS-1, in the same cycle feed_done_out=1.
- ROWS=1: DRAIN lasts one cycle; done coincides with the row-0 output of the last beat.
- A single-beat matrix (first beat is also last) carries both switch and last; this is legal.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs are 0. Release -> stays IDLE, ready=0 until feed_start_in.
- ROWS=2, start, then back-to-back vectors:
  - Stimulus: V0=[0x0200 (2.0), 0xFC9A (-3.3984375)], then V1=[0x135C (19.359375), 0x0459 (4.34765625)] with last.
  - Row 0: 0x0200 with switch=1 in cycle c+1, then 0x135C with switch=0 in c+2.
  - Row 1: 0xFC9A with switch=1 in c+2, then 0x0459 in c+3.
  - feed_done_out=1 only in c+3; busy drops in c+4.
- Bubble: valid=0 for one cycle between V0 and V1 -> each row shows one cycle of valid=0, data=0 between its elements. The switch flag appears only on V0's elements.
- Drain backpressure: valid=1 held through DRAIN -> ready=0 and no extra beats reach the outputs. feed_start_in during DRAIN is ignored; the next start after IDLE re-arms switch.
- Reset mid-stream: rst=0 after V0 is accepted -> all sys_* outputs clear immediately (asynchronously). After release, row 1 never emits 0xFC9A and no done pulse occurs.
- Single-beat matrix [0x0100, 0xFF00] with last -> row 0 valid+switch in c+1, row 1 valid+switch in c+2, and done in c+2.
